vote_capture_controller: RTL and testbench

Front-end sequencer for the voting machine: synchronizes and debounces the four raw candidate buttons, rejects multi-button presses, and owns the four 8-bit vote tallies. It emits the one-cycle `valid_vote_casted` strobe that starts the LED acknowledge timer in the mode/LED controller. It also supplies that controller's `candidateN_vote` inputs. Votes are accepted only in voting mode (`mode` = 0). Tallies are held in result mode.

---
 rtl/vote_capture_controller.sv | 145 ++++++++++++++
 tb/tb_vote_capture_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_capture_controller.sv
// Purpose: synchronize/debounce four candidate buttons, reject multi-presses, own four saturating 8-bit tallies.
// Latency: vote strobe DEBOUNCE_CYCLES+2 edges after a clean press is first sampled; tally visible one edge later.
// Backpressure: none; strobes are fire-and-forget and a held button is never counted twice.
module vote_capture_controller #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1_in,
    input  logic       button2_in,
    input  logic       button3_in,
    input  logic       button4_in,
    output logic       valid_vote_casted,
    output logic       invalid_press,
    output logic       busy,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote
);

    // Counter wide enough to hold DEBOUNCE_CYCLES-1 (minimum one bit).
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        CAST     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic [3:0]    btn_raw;
    logic [3:0]    btn_meta;
    logic [3:0]    btn_p;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    snap;
    logic          snap_onehot;
    logic [7:0]    tally [4];

    assign btn_raw = {button4_in, button3_in, button2_in, button1_in};

    // Assertion propagates immediately; deassertion is released through two flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            btn_meta <= 4'b0000;
            btn_p    <= 4'b0000;
        end else begin
            btn_meta <= btn_raw;
            btn_p    <= btn_meta;
        end
    end

    // Exactly one candidate in the captured press means a valid vote.
    assign snap_onehot = (snap != 4'b0000) && ((snap & (snap - 4'd1)) == 4'b0000);

    // Press sequencer: debounce the press, strobe once, then wait for a clean release.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state             <= IDLE;
            cnt               <= '0;
            snap              <= 4'b0000;
            valid_vote_casted <= 1'b0;
            invalid_press     <= 1'b0;
        end else begin
            valid_vote_casted <= 1'b0;
            invalid_press     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode && (btn_p != 4'b0000)) begin
                        snap  <= btn_p;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // Any change of the pressed set or a switch to result mode abandons the press.
                    if (mode || (btn_p != snap)) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state             <= CAST;
                        valid_vote_casted <= snap_onehot;
                        invalid_press     <= ~snap_onehot;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAST: begin
                    cnt   <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Any activity restarts the quiet-time count, so a held button never re-votes.
                    if (btn_p != 4'b0000) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating tally update on the edge that leaves CAST.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < 4; i++) begin
                tally[i] <= 8'd0;
            end
        end else if ((state == CAST) && snap_onehot) begin
            for (int i = 0; i < 4; i++) begin
                if (snap[i] && (tally[i] != 8'hFF)) begin
                    tally[i] <= tally[i] + 8'd1;
                end
            end
        end
    end

    assign busy            = (state != IDLE);
    assign candidate1_vote = tally[0];
    assign candidate2_vote = tally[1];
    assign candidate3_vote = tally[2];
    assign candidate4_vote = tally[3];

endmodule

// File: tb/tb_vote_capture_controller.sv
// Purpose: scoreboard bench for vote_capture_controller with directed press vectors.
// Latency: expected strobe 19 negedges after a press is driven (D=16), tallies one negedge later.
// Backpressure: none; the monitor flags any strobe with no matching expectation.
module tb_vote_capture_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       valid_vote_casted;
    logic       invalid_press;
    logic       busy;
    logic [7:0] candidate1_vote;
    logic [7:0] candidate2_vote;
    logic [7:0] candidate3_vote;
    logic [7:0] candidate4_vote;

    vote_capture_controller #(.DEBOUNCE_CYCLES(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .button1_in        (btn[0]),
        .button2_in        (btn[1]),
        .button3_in        (btn[2]),
        .button4_in        (btn[3]),
        .valid_vote_casted (valid_vote_casted),
        .invalid_press     (invalid_press),
        .busy              (busy),
        .candidate1_vote   (candidate1_vote),
        .candidate2_vote   (candidate2_vote),
        .candidate3_vote   (candidate3_vote),
        .candidate4_vote   (candidate4_vote)
    );

    typedef struct {
        bit              is_valid;
        int              cyc;
        logic [3:0][7:0] t;
    } exp_item_t;

    exp_item_t       sb [$];
    exp_item_t       pend_it;
    bit              pend = 1'b0;
    logic [3:0][7:0] model = '0;
    int              n_cmp = 0;
    int              n_err = 0;
    int              n_valid_seen = 0;
    int              n_valid_exp = 0;
    int              cyc = 0;
    int              c;
    int              v0;

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(valid_vote_casted), 0);
        chk({tag, "_invalid"}, int'(invalid_press), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_c1"}, int'(candidate1_vote), 0);
        chk({tag, "_c2"}, int'(candidate2_vote), 0);
        chk({tag, "_c3"}, int'(candidate3_vote), 0);
        chk({tag, "_c4"}, int'(candidate4_vote), 0);
    endtask

    // Queue the response a press driven at this negedge should produce.
    task automatic expect_press(input logic [3:0] m);
        exp_item_t it;
        it.cyc = cyc + 19;
        if ($onehot(m)) begin
            it.is_valid = 1'b1;
            n_valid_exp++;
            for (int i = 0; i < 4; i++) begin
                if (m[i] && (model[i] != 8'd255)) model[i] = model[i] + 8'd1;
            end
        end else begin
            it.is_valid = 1'b0;
        end
        it.t = model;
        sb.push_back(it);
    endtask

    task automatic press(input logic [3:0] m, input int hi, input int lo);
        expect_press(m);
        btn = m;
        repeat (hi) @(negedge clock);
        btn = 4'b0000;
        repeat (lo) @(negedge clock);
    endtask

    // Monitor: pop an expectation on every strobe, then check tallies one cycle later.
    initial forever begin
        @(negedge clock);
        if (pend) begin
            chk("tally1", int'(candidate1_vote), int'(pend_it.t[0]));
            chk("tally2", int'(candidate2_vote), int'(pend_it.t[1]));
            chk("tally3", int'(candidate3_vote), int'(pend_it.t[2]));
            chk("tally4", int'(candidate4_vote), int'(pend_it.t[3]));
            pend = 1'b0;
        end
        if (valid_vote_casted || invalid_press) begin
            if (valid_vote_casted) n_valid_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: valid=%0d invalid=%0d at cycle %0d, expected none",
                         valid_vote_casted, invalid_press, cyc);
            end else begin
                pend_it = sb.pop_front();
                chk("pulse_valid", int'(valid_vote_casted), int'(pend_it.is_valid));
                chk("pulse_invalid", int'(invalid_press), int'(!pend_it.is_valid));
                chk("pulse_cycle", cyc, pend_it.cyc);
                pend = 1'b1;
            end
        end
    end

    initial begin
        // Power-on reset: outputs must be zero without any clock edge.
        #1 reset = 1'b0;
        #1 chk_all_zero("por");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        // Single clean press on candidate 2, busy rise/fall timing.
        expect_press(4'b0010);
        c = cyc;
        btn = 4'b0010;
        repeat (2) @(negedge clock);
        chk("busy_before_rise", int'(busy), 0);
        @(negedge clock);
        chk("busy_rise", int'(busy), 1);
        repeat (37) @(negedge clock);
        btn = 4'b0000;
        repeat (17) @(negedge clock);
        chk("busy_release_hold", int'(busy), 1);
        @(negedge clock);
        chk("busy_fall", int'(busy), 0);
        repeat (10) @(negedge clock);

        // Bouncing button 1: toggles every 5 cycles, never stable long enough.
        for (int i = 0; i < 12; i++) begin
            btn = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (5) @(negedge clock);
        end
        btn = 4'b0000;
        repeat (30) @(negedge clock);
        chk("bounce_c1", int'(candidate1_vote), 0);
        chk("bounce_busy", int'(busy), 0);

        // Candidates 3 and 4 together: rejected.
        press(4'b1100, 40, 30);

        // Long hold on candidate 1: exactly one vote.
        press(4'b0001, 500, 30);

        // Result mode ignores presses.
        mode = 1'b1;
        btn = 4'b0010;
        repeat (5) @(negedge clock);
        chk("mode1_busy", int'(busy), 0);
        repeat (35) @(negedge clock);
        btn = 4'b0000;
        repeat (30) @(negedge clock);
        mode = 1'b0;
        repeat (5) @(negedge clock);
        chk("mode1_c2", int'(candidate2_vote), 1);

        // Switch to result mode in the middle of debounce: aborted.
        btn = 4'b0100;
        repeat (10) @(negedge clock);
        chk("abort_busy_pre", int'(busy), 1);
        mode = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_busy_post", int'(busy), 0);
        repeat (28) @(negedge clock);
        btn = 4'b0000;
        repeat (30) @(negedge clock);
        mode = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_c3", int'(candidate3_vote), 0);

        // Build tallies 5/3/0/7.
        for (int i = 0; i < 4; i++) press(4'b0001, 20, 24);
        for (int i = 0; i < 2; i++) press(4'b0010, 20, 24);
        for (int i = 0; i < 7; i++) press(4'b1000, 20, 24);
        chk("pre_rst_c1", int'(candidate1_vote), 5);
        chk("pre_rst_c2", int'(candidate2_vote), 3);
        chk("pre_rst_c3", int'(candidate3_vote), 0);
        chk("pre_rst_c4", int'(candidate4_vote), 7);

        // Asynchronous reset in the middle of debounce.
        btn = 4'b0001;
        repeat (8) @(negedge clock);
        chk("mid_rst_busy", int'(busy), 1);
        #1 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        model = '0;
        btn = 4'b0000;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        press(4'b0001, 20, 24);
        chk("post_rst_c1", int'(candidate1_vote), 1);

        // Saturation: 260 more votes for candidate 1.
        v0 = n_valid_seen;
        for (int i = 0; i < 260; i++) press(4'b0001, 20, 24);
        chk("sat_pulses", n_valid_seen - v0, 260);
        chk("sat_c1", int'(candidate1_vote), 255);

        repeat (20) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        chk("valid_total", n_valid_seen, n_valid_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
